commit_unit: RTL and testbench

COMMIT_UNIT -- requirements
Module: commit_unit

---
 rtl/commit_unit_pkg.sv | 21 ++
 rtl/commit_unit_if.sv | 50 +++++
 rtl/commit_select.sv | 34 +++
 rtl/commit_unit.sv | 110 +++++++++++
 tb/tb_commit_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_unit_pkg.sv
// Shared definitions for the commit stage: widths, FSM states, commit payload.
package commit_unit_pkg;

    localparam int unsigned PRF_NUM_W = 6;
    localparam int unsigned LREG_W    = 5;
    localparam int unsigned XLEN      = 32;
    localparam logic [XLEN-1:0] EXCP_VEC = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } commit_state_e;

    typedef struct packed {
        logic [LREG_W-1:0]    lreg;
        logic [PRF_NUM_W-1:0] preg;
        logic [PRF_NUM_W-1:0] old_preg;
    } commit_req_t;

endpackage

// File: rtl/commit_unit_if.sv
// ROB-head inputs and commit/redirect outputs of the commit stage.
interface commit_unit_if;
    import commit_unit_pkg::*;

    logic                 head_valid_0, head_valid_1;
    logic                 head_done_0, head_done_1;
    logic                 head_wen_0, head_wen_1;
    logic [LREG_W-1:0]    head_lreg_0, head_lreg_1;
    logic [PRF_NUM_W-1:0] head_preg_0, head_preg_1;
    logic [PRF_NUM_W-1:0] head_old_preg_0, head_old_preg_1;
    logic                 head_excp_0, head_excp_1;
    logic                 head_mispred_0, head_mispred_1;
    logic [XLEN-1:0]      head_pc_0, head_pc_1;
    logic [XLEN-1:0]      head_target_0, head_target_1;
    logic                 pause;

    logic                 rob_pop_0, rob_pop_1;
    logic                 commit_valid_0, commit_valid_1;
    logic [LREG_W-1:0]    commit_lreg_0, commit_lreg_1;
    logic [PRF_NUM_W-1:0] commit_preg_0, commit_preg_1;
    logic [PRF_NUM_W-1:0] commit_old_preg_0, commit_old_preg_1;
    logic                 flush, recover, redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic [XLEN-1:0]      commit_count;

    modport master (
        output head_valid_0, head_valid_1, head_done_0, head_done_1,
               head_wen_0, head_wen_1, head_lreg_0, head_lreg_1,
               head_preg_0, head_preg_1, head_old_preg_0, head_old_preg_1,
               head_excp_0, head_excp_1, head_mispred_0, head_mispred_1,
               head_pc_0, head_pc_1, head_target_0, head_target_1, pause,
        input  rob_pop_0, rob_pop_1, commit_valid_0, commit_valid_1,
               commit_lreg_0, commit_lreg_1, commit_preg_0, commit_preg_1,
               commit_old_preg_0, commit_old_preg_1,
               flush, recover, redirect_valid, redirect_pc, commit_count
    );

    modport slave (
        input  head_valid_0, head_valid_1, head_done_0, head_done_1,
               head_wen_0, head_wen_1, head_lreg_0, head_lreg_1,
               head_preg_0, head_preg_1, head_old_preg_0, head_old_preg_1,
               head_excp_0, head_excp_1, head_mispred_0, head_mispred_1,
               head_pc_0, head_pc_1, head_target_0, head_target_1, pause,
        output rob_pop_0, rob_pop_1, commit_valid_0, commit_valid_1,
               commit_lreg_0, commit_lreg_1, commit_preg_0, commit_preg_1,
               commit_old_preg_0, commit_old_preg_1,
               flush, recover, redirect_valid, redirect_pc, commit_count
    );

endinterface

// File: rtl/commit_select.sv
// Combinational slot eligibility: which ROB head entries retire this cycle.
module commit_select (
    input  logic rst,
    input  logic run,
    input  logic pause,
    input  logic head_valid_0,
    input  logic head_done_0,
    input  logic head_excp_0,
    input  logic head_mispred_0,
    input  logic head_valid_1,
    input  logic head_done_1,
    input  logic head_excp_1,
    input  logic head_mispred_1,
    output logic pop0_c,
    output logic pop1_c,
    output logic excp_c,
    output logic mispred0_c,
    output logic mispred1_c
);

    logic head0_ready;

    // Head is retirable in principle; the exception flag decides commit vs trap.
    assign head0_ready = rst & run & !pause & head_valid_0 & head_done_0;

    assign pop0_c     = head0_ready & !head_excp_0;
    assign excp_c     = head0_ready &  head_excp_0;
    assign mispred0_c = pop0_c & head_mispred_0;

    // Slot1 retires only behind a committed, non-redirecting slot0.
    assign pop1_c     = pop0_c & !head_mispred_0 & head_valid_1 & head_done_1 & !head_excp_1;
    assign mispred1_c = pop1_c & head_mispred_1;

endmodule

// File: rtl/commit_unit.sv
// Dual-slot in-order commit: retires ROB heads, releases rename mappings, drives recovery.
module commit_unit
    import commit_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    commit_unit_if.slave cif
);

    commit_state_e   state_q, state_d;
    logic            cv0_q, cv0_d, cv1_q, cv1_d;
    commit_req_t     req0_q, req0_d, req1_q, req1_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] count_q, count_d;

    logic pop0, pop1, excp, mispred0, mispred1;
    logic unused_pc_c;

    assign unused_pc_c = ^{cif.head_pc_0, cif.head_pc_1};

    commit_select u_select (
        .rst            (rst),
        .run            (state_q == ST_RUN),
        .pause          (cif.pause),
        .head_valid_0   (cif.head_valid_0),
        .head_done_0    (cif.head_done_0),
        .head_excp_0    (cif.head_excp_0),
        .head_mispred_0 (cif.head_mispred_0),
        .head_valid_1   (cif.head_valid_1),
        .head_done_1    (cif.head_done_1),
        .head_excp_1    (cif.head_excp_1),
        .head_mispred_1 (cif.head_mispred_1),
        .pop0_c         (pop0),
        .pop1_c         (pop1),
        .excp_c         (excp),
        .mispred0_c     (mispred0),
        .mispred1_c     (mispred1)
    );

    // Next state, commit payload capture, redirect target and retire counter.
    always_comb begin
        state_d       = state_q;
        cv0_d         = pop0 & cif.head_wen_0;
        cv1_d         = pop1 & cif.head_wen_1;
        req0_d        = req0_q;
        req1_d        = req1_q;
        redirect_pc_d = redirect_pc_q;
        count_d       = count_q + 32'(pop0) + 32'(pop1);
        if (pop0) req0_d = '{cif.head_lreg_0, cif.head_preg_0, cif.head_old_preg_0};
        if (pop1) req1_d = '{cif.head_lreg_1, cif.head_preg_1, cif.head_old_preg_1};
        unique case (state_q)
            ST_RUN: begin
                if (excp) begin
                    state_d       = ST_FLUSH;
                    redirect_pc_d = EXCP_VEC;
                end else if (mispred0) begin
                    state_d       = ST_FLUSH;
                    redirect_pc_d = cif.head_target_0;
                end else if (mispred1) begin
                    state_d       = ST_FLUSH;
                    redirect_pc_d = cif.head_target_1;
                end
            end
            ST_FLUSH: state_d = ST_DRAIN;
            ST_DRAIN: if (!cif.head_valid_0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        flush_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            cv0_q         <= 1'b0;
            cv1_q         <= 1'b0;
            req0_q        <= '0;
            req1_q        <= '0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cv0_q         <= cv0_d;
            cv1_q         <= cv1_d;
            req0_q        <= req0_d;
            req1_q        <= req1_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            count_q       <= count_d;
        end
    end

    assign cif.rob_pop_0         = pop0;
    assign cif.rob_pop_1         = pop1;
    assign cif.commit_valid_0    = cv0_q;
    assign cif.commit_valid_1    = cv1_q;
    assign cif.commit_lreg_0     = req0_q.lreg;
    assign cif.commit_preg_0     = req0_q.preg;
    assign cif.commit_old_preg_0 = req0_q.old_preg;
    assign cif.commit_lreg_1     = req1_q.lreg;
    assign cif.commit_preg_1     = req1_q.preg;
    assign cif.commit_old_preg_1 = req1_q.old_preg;
    assign cif.flush             = flush_q;
    assign cif.recover           = flush_q;
    assign cif.redirect_valid    = flush_q;
    assign cif.redirect_pc       = redirect_pc_q;
    assign cif.commit_count      = count_q;

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: directed ROB-head vectors, queued expectations.
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic clk;
    logic rst;
    commit_unit_if cif();

    commit_unit dut (.clk(clk), .rst(rst), .cif(cif.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    commit_req_t q0[$];
    commit_req_t q1[$];
    logic [31:0] qf[$];
    logic [31:0] exp_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set0(input logic v, input logic d, input logic w, input logic [4:0] l,
                        input logic [5:0] p, input logic [5:0] o, input logic ex,
                        input logic mp, input logic [31:0] tgt);
        cif.head_valid_0 = v; cif.head_done_0 = d; cif.head_wen_0 = w;
        cif.head_lreg_0 = l; cif.head_preg_0 = p; cif.head_old_preg_0 = o;
        cif.head_excp_0 = ex; cif.head_mispred_0 = mp; cif.head_target_0 = tgt;
        cif.head_pc_0 = 32'h0000_1000;
    endtask

    task automatic set1(input logic v, input logic d, input logic w, input logic [4:0] l,
                        input logic [5:0] p, input logic [5:0] o, input logic ex,
                        input logic mp, input logic [31:0] tgt);
        cif.head_valid_1 = v; cif.head_done_1 = d; cif.head_wen_1 = w;
        cif.head_lreg_1 = l; cif.head_preg_1 = p; cif.head_old_preg_1 = o;
        cif.head_excp_1 = ex; cif.head_mispred_1 = mp; cif.head_target_1 = tgt;
        cif.head_pc_1 = 32'h0000_1004;
    endtask

    task automatic idle();
        set0(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pop(input string name, input logic e0, input logic e1);
        #1;
        chk({name, "_pop0"}, 32'(cif.rob_pop_0), 32'(e0));
        chk({name, "_pop1"}, 32'(cif.rob_pop_1), 32'(e1));
    endtask

    task automatic exp_c0(input logic [4:0] l, input logic [5:0] p, input logic [5:0] o);
        q0.push_back('{l, p, o});
    endtask

    task automatic exp_c1(input logic [4:0] l, input logic [5:0] p, input logic [5:0] o);
        q1.push_back('{l, p, o});
    endtask

    // Walk FLUSH then DRAIN with a busy head, then empty the ROB to return to RUN.
    task automatic drain_seq(input string name);
        set0(1, 1, 1, 1, 1, 1, 0, 0, 0);
        chk_pop({name, "_flush"}, 0, 0);
        cyc();
        chk_pop({name, "_drain_a"}, 0, 0);
        cyc();
        chk_pop({name, "_drain_b"}, 0, 0);
        idle();
        cyc();
    endtask

    // Monitor: every registered commit or flush the DUT presents must match a queued expectation.
    initial begin
        commit_req_t e;
        logic [31:0] f;
        forever begin
            @(negedge clk);
            if (cif.commit_valid_0) begin
                if (q0.size() == 0) chk("cv0_unexpected", 32'(cif.commit_valid_0), 0);
                else begin
                    e = q0.pop_front();
                    chk("cv0_payload", 32'({cif.commit_lreg_0, cif.commit_preg_0, cif.commit_old_preg_0}), 32'(e));
                end
            end
            if (cif.commit_valid_1) begin
                if (q1.size() == 0) chk("cv1_unexpected", 32'(cif.commit_valid_1), 0);
                else begin
                    e = q1.pop_front();
                    chk("cv1_payload", 32'({cif.commit_lreg_1, cif.commit_preg_1, cif.commit_old_preg_1}), 32'(e));
                end
            end
            if (cif.flush) begin
                if (qf.size() == 0) chk("flush_unexpected", 32'(cif.flush), 0);
                else begin
                    f = qf.pop_front();
                    chk("redirect_pc", cif.redirect_pc, f);
                    chk("recover", 32'(cif.recover), 1);
                    chk("redirect_valid", 32'(cif.redirect_valid), 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        cif.pause = 1'b0;
        idle();
        exp_count = 0;
        cyc();
        cyc();
        // Reset state, and pops forced low while reset is held.
        set0(1, 1, 1, 1, 1, 1, 0, 0, 0);
        set1(1, 1, 1, 2, 2, 2, 0, 0, 0);
        chk_pop("rst", 0, 0);
        chk("rst_cv0", 32'(cif.commit_valid_0), 0);
        chk("rst_flush", 32'(cif.flush), 0);
        chk("rst_redirect_pc", cif.redirect_pc, 0);
        chk("rst_count", cif.commit_count, 0);
        idle();
        rst = 1'b1;
        cyc();

        // Two done ALU ops.
        set0(1, 1, 1, 5'd1, 6'd10, 6'd3, 0, 0, 0);
        set1(1, 1, 1, 5'd2, 6'd11, 6'd4, 0, 0, 0);
        chk_pop("dual", 1, 1);
        exp_c0(5'd1, 6'd10, 6'd3); exp_c1(5'd2, 6'd11, 6'd4); exp_count += 2;
        cyc();
        chk("dual_count", cif.commit_count, exp_count);

        // Slot1 not done.
        set0(1, 1, 1, 5'd7, 6'd20, 6'd8, 0, 0, 0);
        set1(1, 0, 1, 5'd9, 6'd21, 6'd9, 0, 0, 0);
        chk_pop("single", 1, 0);
        exp_c0(5'd7, 6'd20, 6'd8); exp_count += 1;
        cyc();
        chk("single_count", cif.commit_count, exp_count);

        // Slot0 has no destination: pops but no release.
        set0(1, 1, 0, 5'd9, 6'd30, 6'd31, 0, 0, 0);
        set1(1, 1, 1, 5'd3, 6'd33, 6'd34, 0, 0, 0);
        chk_pop("nowen", 1, 1);
        exp_c1(5'd3, 6'd33, 6'd34); exp_count += 2;
        cyc();
        chk("nowen_count", cif.commit_count, exp_count);

        // Slot1 exception waits until it becomes head.
        set0(1, 1, 1, 5'd4, 6'd40, 6'd41, 0, 0, 0);
        set1(1, 1, 1, 5'd5, 6'd42, 6'd43, 1, 0, 0);
        chk_pop("excp1", 1, 0);
        exp_c0(5'd4, 6'd40, 6'd41); exp_count += 1;
        cyc();
        chk("excp1_count", cif.commit_count, exp_count);

        // Empty ROB ignores slot1.
        set0(0, 1, 1, 5'd6, 6'd1, 6'd2, 0, 0, 0);
        set1(1, 1, 1, 5'd7, 6'd3, 6'd4, 0, 0, 0);
        chk_pop("empty", 0, 0);
        cyc();
        chk("empty_count", cif.commit_count, exp_count);

        // Pause blocks, release retires both.
        cif.pause = 1'b1;
        set0(1, 1, 1, 5'd10, 6'd50, 6'd51, 0, 0, 0);
        set1(1, 1, 1, 5'd11, 6'd52, 6'd53, 0, 0, 0);
        chk_pop("pause", 0, 0);
        cyc();
        chk("pause_count", cif.commit_count, exp_count);
        cif.pause = 1'b0;
        chk_pop("unpause", 1, 1);
        exp_c0(5'd10, 6'd50, 6'd51); exp_c1(5'd11, 6'd52, 6'd53); exp_count += 2;
        cyc();
        chk("unpause_count", cif.commit_count, exp_count);

        // Mispredict committed from slot1.
        set0(1, 1, 1, 5'd12, 6'd54, 6'd55, 0, 0, 0);
        set1(1, 1, 1, 5'd13, 6'd56, 6'd57, 0, 1, 32'h0000_4000);
        chk_pop("mp1", 1, 1);
        exp_c0(5'd12, 6'd54, 6'd55); exp_c1(5'd13, 6'd56, 6'd57); exp_count += 2;
        qf.push_back(32'h0000_4000);
        cyc();
        chk("mp1_count", cif.commit_count, exp_count);
        drain_seq("mp1");

        // Mispredict in slot0 blocks slot1.
        set0(1, 1, 1, 5'd5, 6'd12, 6'd6, 0, 1, 32'h8000_0100);
        set1(1, 1, 1, 5'd8, 6'd13, 6'd7, 0, 0, 0);
        chk_pop("mp0", 1, 0);
        exp_c0(5'd5, 6'd12, 6'd6); exp_count += 1;
        qf.push_back(32'h8000_0100);
        cyc();
        chk("mp0_redirect", cif.redirect_pc, 32'h8000_0100);
        drain_seq("mp0");
        set0(1, 1, 1, 5'd14, 6'd14, 6'd15, 0, 0, 0);
        chk_pop("mp0_rerun", 1, 0);
        exp_c0(5'd14, 6'd14, 6'd15); exp_count += 1;
        cyc();
        chk("mp0_count", cif.commit_count, exp_count);

        // Exception at head.
        set0(1, 1, 1, 5'd15, 6'd16, 6'd17, 1, 0, 0);
        set1(1, 1, 1, 5'd16, 6'd18, 6'd19, 0, 0, 0);
        chk_pop("excp0", 0, 0);
        qf.push_back(32'hBFC0_0380);
        cyc();
        chk("excp0_cv0", 32'(cif.commit_valid_0), 0);
        chk("excp0_count", cif.commit_count, exp_count);
        drain_seq("excp0");

        // Reset in FLUSH aborts recovery.
        set0(1, 1, 1, 5'd17, 6'd20, 6'd21, 1, 0, 0);
        chk_pop("rstflush", 0, 0);
        qf.push_back(32'hBFC0_0380);
        cyc();
        idle();
        @(negedge clk);
        #1;
        rst = 1'b0;
        set0(1, 1, 1, 5'd18, 6'd22, 6'd23, 0, 0, 0);
        cyc();
        exp_count = 0;
        chk("rstflush_flush", 32'(cif.flush), 0);
        chk("rstflush_pc", cif.redirect_pc, 0);
        chk("rstflush_count", cif.commit_count, exp_count);
        chk_pop("rstflush_held", 0, 0);
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        chk("rstflush_noflush", 32'(cif.flush), 0);
        set0(1, 1, 1, 5'd19, 6'd24, 6'd25, 0, 0, 0);
        chk_pop("post_rst", 1, 0);
        exp_c0(5'd19, 6'd24, 6'd25); exp_count += 1;
        cyc();
        chk("post_rst_count", cif.commit_count, exp_count);
        idle();
        cyc();
        cyc();

        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("qf_drained", 32'(qf.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
